comparador_jog: RTL and testbench

//  Player-move comparator for the game datapath.
//  - A (8 bits) is split into 4 lanes of 2 bits; B (4 bits) holds one select bit per lane.
//  - acerto flags a hit when any selected lane of A holds the target code 2'b00.
//  - Combinational hit logic feeds the game FSM directly.
//  - A registered copy, a per-lane hit mask and a saturating hit counter feed scoring/debug.

---
 rtl/comparador_jog.sv | 63 ++++++
 tb/tb_comparador_jog.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/comparador_jog.sv
// Player-move comparator: per-lane hit detection on A gated by B, plus a registered
// hit flag and a saturating hit counter for scoring/debug.
module comparador_jog #(
  parameter int                N_LANES = 4,
  parameter int                LANE_W  = 2,
  parameter logic [LANE_W-1:0] TARGET  = 2'b00,
  parameter int                CNT_W   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_LANES*LANE_W-1:0]   A,
  input  logic [N_LANES-1:0]          B,
  input  logic                        conta,
  input  logic                        zera_conta,
  output logic                        acerto,
  output logic [N_LANES-1:0]          acertos,
  output logic                        acerto_reg,
  output logic [CNT_W-1:0]            conta_acertos
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX)
      return c;
    else
      return c + 1'b1;
  endfunction

  logic [N_LANES-1:0] hit_p0;
  logic               vld_p0;
  logic               acerto_p1;
  logic [CNT_W-1:0]   cnt_p1;

  // Stage p0: combinational lane compare, feeds the game FSM with zero latency
  always_comb begin
    hit_p0 = '0;
    for (int i = 0; i < N_LANES; i++)
      hit_p0[i] = B[i] && (A[LANE_W*i +: LANE_W] == TARGET);
  end

  assign vld_p0  = |hit_p0;
  assign acertos = hit_p0;
  assign acerto  = vld_p0;

  // Stage p1: registered hit flag and saturating counter (clear wins over count)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acerto_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      acerto_p1 <= vld_p0;
      if (zera_conta)
        cnt_p1 <= '0;
      else if (conta && vld_p0)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign acerto_reg    = acerto_p1;
  assign conta_acertos = cnt_p1;

endmodule

// File: tb/tb_comparador_jog.sv
// Directed self-checking bench for comparador_jog: lane mapping, boundaries,
// counter saturation/clear and asynchronous reset behaviour.
module tb_comparador_jog;

  logic       clock;
  logic       reset;
  logic [7:0] A;
  logic [3:0] B;
  logic       conta;
  logic       zera_conta;
  logic       acerto;
  logic [3:0] acertos;
  logic       acerto_reg;
  logic [7:0] conta_acertos;

  int checks = 0;
  int errors = 0;

  comparador_jog dut (
    .clock        (clock),
    .reset        (reset),
    .A            (A),
    .B            (B),
    .conta        (conta),
    .zera_conta   (zera_conta),
    .acerto       (acerto),
    .acertos      (acertos),
    .acerto_reg   (acerto_reg),
    .conta_acertos(conta_acertos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    A          = 8'hFF;
    B          = 4'hF;
    conta      = 1'b0;
    zera_conta = 1'b0;

    // power-up reset
    #2 reset = 1'b1;
    #1;
    check("rst_acerto_reg", {31'b0, acerto_reg}, 32'd0);
    check("rst_count", {24'b0, conta_acertos}, 32'd0);
    @(posedge clock); #1;
    check("rst_hold_count", {24'b0, conta_acertos}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // 1: no lane at 00
    A = 8'hFF; B = 4'hF; #1;
    check("t1_acerto", {31'b0, acerto}, 32'd0);
    check("t1_acertos", {28'b0, acertos}, 32'h0);
    @(posedge clock); #1;
    check("t1_acerto_reg", {31'b0, acerto_reg}, 32'd0);

    // 2: lane3 hit
    @(negedge clock);
    A = 8'b00111111; B = 4'b1000; #1;
    check("t2_acerto", {31'b0, acerto}, 32'd1);
    check("t2_acertos", {28'b0, acertos}, 32'h8);
    @(posedge clock); #1;
    check("t2_acerto_reg", {31'b0, acerto_reg}, 32'd1);
    check("t2_count_idle", {24'b0, conta_acertos}, 32'd0);

    // 3: lane0 hit, lane1 (01) not a hit
    @(negedge clock);
    A = 8'b11100100; B = 4'b0001; #1;
    check("t3_acerto", {31'b0, acerto}, 32'd1);
    check("t3_acertos", {28'b0, acertos}, 32'h1);
    B = 4'b0010; #1;
    check("t3_lane1_acerto", {31'b0, acerto}, 32'd0);
    check("t3_lane1_acertos", {28'b0, acertos}, 32'h0);
    @(posedge clock); #1;
    check("t3_acerto_reg", {31'b0, acerto_reg}, 32'd0);

    // 4: all lanes / no select
    @(negedge clock);
    A = 8'h00; B = 4'hF; #1;
    check("t4_acerto_all", {31'b0, acerto}, 32'd1);
    check("t4_acertos_all", {28'b0, acertos}, 32'hF);
    B = 4'h0; #1;
    check("t4_acerto_none", {31'b0, acerto}, 32'd0);
    check("t4_acertos_none", {28'b0, acertos}, 32'h0);

    // 5: counting, multi-lane adds +1, hold without hit, saturation, clear priority
    @(negedge clock);
    B = 4'hF; conta = 1'b1;
    @(posedge clock); #1;
    check("t5_count_first", {24'b0, conta_acertos}, 32'd1);
    @(negedge clock);
    B = 4'h0;
    @(posedge clock); #1;
    check("t5_count_hold", {24'b0, conta_acertos}, 32'd1);
    check("t5_acerto_reg_low", {31'b0, acerto_reg}, 32'd0);
    @(negedge clock);
    B = 4'hF;
    repeat (253) @(posedge clock);
    #1;
    check("t5_count_254", {24'b0, conta_acertos}, 32'd254);
    @(posedge clock); #1;
    check("t5_count_255", {24'b0, conta_acertos}, 32'd255);
    repeat (46) @(posedge clock);
    #1;
    check("t5_count_sat", {24'b0, conta_acertos}, 32'd255);
    @(negedge clock);
    zera_conta = 1'b1;
    @(posedge clock); #1;
    check("t5_clear_wins", {24'b0, conta_acertos}, 32'd0);
    @(negedge clock);
    zera_conta = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("t5_recount", {24'b0, conta_acertos}, 32'd3);

    // 6: asynchronous reset between edges while counting
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_count", {24'b0, conta_acertos}, 32'd0);
    check("t6_rst_acerto_reg", {31'b0, acerto_reg}, 32'd0);
    check("t6_rst_acerto_follow", {31'b0, acerto}, 32'd1);
    B = 4'h0; #1;
    check("t6_rst_acerto_b0", {31'b0, acerto}, 32'd0);
    check("t6_rst_acertos_b0", {28'b0, acertos}, 32'h0);
    B = 4'hF;
    @(posedge clock); #1;
    check("t6_rst_hold_count", {24'b0, conta_acertos}, 32'd0);
    check("t6_rst_hold_reg", {31'b0, acerto_reg}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("t6_resume_count", {24'b0, conta_acertos}, 32'd1);
    check("t6_resume_reg", {31'b0, acerto_reg}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
